// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer_if
// Brief    : Control/fetch bundle between decode/ALU and the fetch sequencer.
//            PC_SEQ_CYCLE_CNT_EN adds the cycle_count return signal.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
    parameter int PC_W = 9
);
    logic            start;
    logic [PC_W-1:0] start_addr;
    logic            jump_req;
    logic            jump_en;
    logic [PC_W-1:0] jump_addr;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            halt_req;
    logic [PC_W-1:0] pc;
    logic            read_jump;
    logic            busy;
    logic            done;
    logic            err;
`ifdef PC_SEQ_CYCLE_CNT_EN
    logic [15:0]     cycle_count;
`endif

    modport master (
        output start, start_addr, jump_req, jump_en, jump_addr,
               branch_taken, branch_target, halt_req,
        input  pc, read_jump, busy, done, err
`ifdef PC_SEQ_CYCLE_CNT_EN
        , input cycle_count
`endif
    );

    modport slave (
        input  start, start_addr, jump_req, jump_en, jump_addr,
               branch_taken, branch_target, halt_req,
        output pc, read_jump, busy, done, err
`ifdef PC_SEQ_CYCLE_CNT_EN
        , output cycle_count
`endif
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Program counter, start/halt handshake and two-word JR sequencing.
//            Optional macro PC_SEQ_CYCLE_CNT_EN adds a saturating busy-cycle
//            counter (cycle_count).
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int PC_W = 9
) (
    input  wire           Clk,
    input  wire           Reset,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        JTGT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] c_pc_one = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_read_jump;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
`ifdef PC_SEQ_CYCLE_CNT_EN
    logic [15:0]     r_cycle_count;
`endif

    // Outputs are registered alongside the state so they always equal the
    // decode of the state actually held.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_err       <= 1'b0;
            r_read_jump <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef PC_SEQ_CYCLE_CNT_EN
            r_cycle_count <= 16'd0;
`endif
        end else begin
`ifdef PC_SEQ_CYCLE_CNT_EN
            if (r_busy && (r_cycle_count != 16'hFFFF)) begin
                r_cycle_count <= r_cycle_count + 16'd1;
            end
`endif
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_pc    <= bus.start_addr;
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
`ifdef PC_SEQ_CYCLE_CNT_EN
                        r_cycle_count <= 16'd0;
`endif
                    end
                end
                RUN: begin
                    if (bus.halt_req) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (bus.jump_req) begin
                        r_pc        <= r_pc + c_pc_one;
                        r_state     <= JTGT;
                        r_read_jump <= 1'b1;
                    end else if (bus.branch_taken) begin
                        r_pc <= bus.branch_target;
                    end else begin
                        r_pc <= r_pc + c_pc_one;
                    end
                end
                JTGT: begin
                    // The word fetched here is data, so only jump_en matters.
                    r_state     <= RUN;
                    r_read_jump <= 1'b0;
                    if (bus.jump_en) begin
                        r_pc <= bus.jump_addr;
                    end else begin
                        r_pc  <= r_pc + c_pc_one;
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_read_jump <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc        = r_pc;
    assign bus.read_jump = r_read_jump;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
`ifdef PC_SEQ_CYCLE_CNT_EN
    assign bus.cycle_count = r_cycle_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed self-checking bench for pc_sequencer (PC_W = 9).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;
    localparam int PC_W = 9;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    pc_sequencer_if #(.PC_W(PC_W)) bus ();

    pc_sequencer #(.PC_W(PC_W)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_ctrl();
        bus.start         = 1'b0;
        bus.start_addr    = '0;
        bus.jump_req      = 1'b0;
        bus.jump_en       = 1'b0;
        bus.jump_addr     = '0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.halt_req      = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        clear_ctrl();
        tick();
        tick();
        check("rst_pc", 16'(bus.pc), 16'h000);
        check("rst_busy", 16'(bus.busy), 16'h0);
        check("rst_done", 16'(bus.done), 16'h0);
        check("rst_rj", 16'(bus.read_jump), 16'h0);
        check("rst_err", 16'(bus.err), 16'h0);

        // Start and sequential stepping
        rst = 1'b0;
        bus.start = 1'b1; bus.start_addr = 9'h010;
        tick();
        clear_ctrl();
        check("start_pc", 16'(bus.pc), 16'h010);
        check("start_busy", 16'(bus.busy), 16'h1);
        tick(); check("seq1_pc", 16'(bus.pc), 16'h011);
        tick(); check("seq2_pc", 16'(bus.pc), 16'h012);
        tick(); check("seq3_pc", 16'(bus.pc), 16'h013);

        // Branch
        bus.branch_taken = 1'b1; bus.branch_target = 9'h020;
        tick();
        clear_ctrl();
        check("br_pc", 16'(bus.pc), 16'h020);

        // JR with valid target; halt/branch in JTGT must be ignored
        bus.jump_req = 1'b1;
        tick();
        clear_ctrl();
        check("jr_pc", 16'(bus.pc), 16'h021);
        check("jr_rj", 16'(bus.read_jump), 16'h1);
        check("jr_busy", 16'(bus.busy), 16'h1);
        bus.jump_en = 1'b1; bus.jump_addr = 9'h0A5;
        bus.halt_req = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 9'h055;
        bus.jump_req = 1'b1;
        tick();
        clear_ctrl();
        check("jt_pc", 16'(bus.pc), 16'h0A5);
        check("jt_rj", 16'(bus.read_jump), 16'h0);
        check("jt_err", 16'(bus.err), 16'h0);
        check("jt_done", 16'(bus.done), 16'h0);

        // JR without jump_en -> sticky error
        bus.jump_req = 1'b1;
        tick();
        clear_ctrl();
        check("jr2_pc", 16'(bus.pc), 16'h0A6);
        tick();
        check("perr_pc", 16'(bus.pc), 16'h0A7);
        check("perr_err", 16'(bus.err), 16'h1);
        check("perr_rj", 16'(bus.read_jump), 16'h0);

        // Priority: halt beats jump and branch
        bus.branch_taken = 1'b1; bus.branch_target = 9'h030;
        tick();
        clear_ctrl();
        check("br2_pc", 16'(bus.pc), 16'h030);
        bus.halt_req = 1'b1; bus.jump_req = 1'b1;
        bus.branch_taken = 1'b1; bus.branch_target = 9'h0F0;
        tick();
        clear_ctrl();
        check("halt_pc", 16'(bus.pc), 16'h030);
        check("halt_done", 16'(bus.done), 16'h1);
        check("halt_busy", 16'(bus.busy), 16'h0);
        check("halt_rj", 16'(bus.read_jump), 16'h0);
        check("halt_err", 16'(bus.err), 16'h1);
        tick();
        check("done_hold_pc", 16'(bus.pc), 16'h030);
        check("done_hold", 16'(bus.done), 16'h1);

        // Restart from DONE keeps err
        bus.start = 1'b1; bus.start_addr = 9'h000;
        tick();
        clear_ctrl();
        check("rs_pc", 16'(bus.pc), 16'h000);
        check("rs_busy", 16'(bus.busy), 16'h1);
        check("rs_done", 16'(bus.done), 16'h0);
        check("rs_err", 16'(bus.err), 16'h1);

        // start ignored while busy
        bus.start = 1'b1; bus.start_addr = 9'h1FF;
        tick();
        clear_ctrl();
        check("busy_start_pc", 16'(bus.pc), 16'h001);
        bus.halt_req = 1'b1;
        tick();
        clear_ctrl();
        check("halt2_pc", 16'(bus.pc), 16'h001);

        // Wrap
        bus.start = 1'b1; bus.start_addr = 9'h1FF;
        tick();
        clear_ctrl();
        check("wrap_start_pc", 16'(bus.pc), 16'h1FF);
        tick();
        check("wrap_pc", 16'(bus.pc), 16'h000);
        bus.branch_taken = 1'b1; bus.branch_target = 9'h1FF;
        tick();
        clear_ctrl();
        check("wrap_br_pc", 16'(bus.pc), 16'h1FF);
        bus.jump_req = 1'b1;
        tick();
        clear_ctrl();
        check("wrap_jr_pc", 16'(bus.pc), 16'h000);
        check("wrap_jr_rj", 16'(bus.read_jump), 16'h1);

        // Reset during JTGT beats start
        rst = 1'b1; bus.start = 1'b1; bus.start_addr = 9'h0AA;
        bus.jump_en = 1'b1; bus.jump_addr = 9'h055;
        tick();
        rst = 1'b0;
        clear_ctrl();
        check("rj_rst_pc", 16'(bus.pc), 16'h000);
        check("rj_rst_rj", 16'(bus.read_jump), 16'h0);
        check("rj_rst_busy", 16'(bus.busy), 16'h0);
        check("rj_rst_err", 16'(bus.err), 16'h0);

        // IDLE ignores control other than start
        bus.branch_taken = 1'b1; bus.branch_target = 9'h077;
        bus.jump_req = 1'b1;
        tick();
        clear_ctrl();
        check("idle_pc", 16'(bus.pc), 16'h000);
        check("idle_busy", 16'(bus.busy), 16'h0);
        check("idle_done", 16'(bus.done), 16'h0);

`ifdef PC_SEQ_CYCLE_CNT_EN
        bus.start = 1'b1; bus.start_addr = 9'h100;
        tick();
        clear_ctrl();
        check("cnt_start", bus.cycle_count, 16'd0);
        tick();
        tick();
        tick();
        tick();
        check("cnt_run4", bus.cycle_count, 16'd4);
        bus.halt_req = 1'b1;
        tick();
        clear_ctrl();
        check("cnt_halt", bus.cycle_count, 16'd5);
        tick();
        check("cnt_hold", bus.cycle_count, 16'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
